// File: rtl/johnson_step_ctrl_pkg.sv
// Shared types for the Johnson step controller: FSM state encoding and
// direction constants.
package johnson_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

endpackage

// File: rtl/johnson_step_ctrl_if.sv
// Move-command handshake between a host and the Johnson step controller.
// The host holds cmd_valid and the command fields until cmd_ready is seen.
interface johnson_step_ctrl_if #(
  parameter int CNT_W = 8,
  parameter int DIV_W = 8
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_steps;
  logic [DIV_W-1:0] cmd_div;

  modport master (
    output cmd_valid,
    output cmd_dir,
    output cmd_steps,
    output cmd_div,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_dir,
    input  cmd_steps,
    input  cmd_div,
    output cmd_ready
  );

endinterface

// File: rtl/johnson_shift.sv
// Bidirectional Johnson phase register. Reverse is the exact inverse of
// forward, so alternating directions retraces the same 2*WIDTH sequence.
module johnson_shift
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             dir,
  output logic [WIDTH-1:0] phase
);

  function automatic logic [WIDTH-1:0] johnson_fwd(input logic [WIDTH-1:0] p);
    return {p[WIDTH-2:0], ~p[WIDTH-1]};
  endfunction

  function automatic logic [WIDTH-1:0] johnson_rev(input logic [WIDTH-1:0] p);
    return {~p[0], p[WIDTH-1:1]};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase <= '0;
    end else if (step) begin
      phase <= (dir == DIR_REV) ? johnson_rev(phase) : johnson_fwd(phase);
    end
  end

endmodule

// File: rtl/johnson_step_ctrl.sv
// Command-driven sequencer: accepts one move at a time and advances a
// Johnson phase counter at a programmed step period, with abort support.
module johnson_step_ctrl
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  parameter int DIV_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  johnson_step_ctrl_if.slave cmd,
  input  logic               abort,
  output logic [WIDTH-1:0]   phase,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   steps_left
);

  state_t           state;
  state_t           state_nx;
  logic             accept;
  logic             step;
  logic             last_step;
  logic             dir_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] pre;

  // accept is decoded from state rather than cmd_ready to keep the
  // handshake free of a combinational loop through the interface.
  assign accept    = cmd.cmd_valid && (state == IDLE);
  assign step      = (state == RUN) && !abort && (pre == '0);
  assign last_step = step && (steps_left == CNT_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    cmd.cmd_ready = 1'b0;
    busy          = 1'b0;
    case (state)
      IDLE: begin
        cmd.cmd_ready = 1'b1;
        if (cmd.cmd_valid) begin
          state_nx = (cmd.cmd_steps != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (abort || last_step) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Prescaler and step counter; abort freezes both so steps_left keeps the
  // unissued count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre        <= '0;
      steps_left <= '0;
      dir_q      <= DIR_FWD;
      div_q      <= '0;
      done       <= 1'b0;
    end else begin
      done <= (state_nx == DONE);
      if (accept) begin
        dir_q      <= cmd.cmd_dir;
        div_q      <= cmd.cmd_div;
        pre        <= cmd.cmd_div;
        steps_left <= cmd.cmd_steps;
      end else if ((state == RUN) && !abort) begin
        if (pre != '0) begin
          pre <= pre - DIV_W'(1);
        end else begin
          pre        <= div_q;
          steps_left <= steps_left - CNT_W'(1);
        end
      end
    end
  end

  johnson_shift #(
    .WIDTH(WIDTH)
  ) u_shift (
    .clk  (clk),
    .rst  (rst),
    .step (step),
    .dir  (dir_q),
    .phase(phase)
  );

endmodule

// File: tb/tb_johnson_step_ctrl.sv
// Directed and randomized moves checked cycle by cycle against a model that
// tracks the motor position as an integer modulo 2*WIDTH.
module tb_johnson_step_ctrl;
  import johnson_pkg::*;

  localparam int W  = 4;
  localparam int CW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          abort;
  logic [W-1:0]  phase;
  logic          busy;
  logic          done;
  logic [CW-1:0] steps_left;

  int checks   = 0;
  int failures = 0;
  int pos      = 0;

  always #5 clk = ~clk;

  johnson_step_ctrl_if #(.CNT_W(CW), .DIV_W(DW)) cif ();

  johnson_step_ctrl #(
    .WIDTH(W),
    .CNT_W(CW),
    .DIV_W(DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cif),
    .abort     (abort),
    .phase     (phase),
    .busy      (busy),
    .done      (done),
    .steps_left(steps_left)
  );

  // Johnson pattern at position p: p ones filling from the LSB, then zeros
  // filling from the LSB for the second half of the cycle.
  function automatic logic [W-1:0] pat(input int p);
    logic [31:0] v;
    if (p <= W) v = (32'd1 << p) - 32'd1;
    else        v = ((32'd1 << W) - 32'd1) ^ ((32'd1 << (p - W)) - 32'd1);
    return v[W-1:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. Runs one move to completion; nv/ndir/nn/ndiv are
  // driven onto the command bus right after acceptance (to hold a next command).
  task automatic do_move(input bit dir, input int n, input int div, input int abort_at,
                         input bit nv, input bit ndir, input int nn, input int ndiv);
    int issued = 0;
    int c = 0;
    int wait_cyc = 0;
    bit running;
    bit ab;
    cif.cmd_dir   = dir;
    cif.cmd_steps = n[CW-1:0];
    cif.cmd_div   = div[DW-1:0];
    cif.cmd_valid = 1'b1;
    while (cif.cmd_ready !== 1'b1 && wait_cyc < 200) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (wait_cyc >= 200) begin
      chk("accept_timeout", {31'd0, cif.cmd_ready}, 32'd1);
      cif.cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    cif.cmd_valid = nv;
    cif.cmd_dir   = ndir;
    cif.cmd_steps = nn[CW-1:0];
    cif.cmd_div   = ndiv[DW-1:0];
    running = (n != 0);
    chk("acc_phase", {28'd0, phase}, {28'd0, pat(pos)});
    chk("acc_left", {24'd0, steps_left}, n - issued);
    chk("acc_busy", {31'd0, busy}, {31'd0, running});
    chk("acc_done", {31'd0, done}, {31'd0, !running});
    chk("acc_ready", {31'd0, cif.cmd_ready}, 32'd0);
    while (running && c < n * (div + 1) + 4) begin
      ab = (abort_at >= 0) && (issued == abort_at);
      abort = ab;
      @(posedge clk);
      c++;
      if (ab) begin
        running = 1'b0;
      end else if (c % (div + 1) == 0) begin
        issued++;
        pos = (pos + (dir ? 2 * W - 1 : 1)) % (2 * W);
        if (issued == n) running = 1'b0;
      end
      @(negedge clk);
      abort = 1'b0;
      chk("run_phase", {28'd0, phase}, {28'd0, pat(pos)});
      chk("run_left", {24'd0, steps_left}, n - issued);
      chk("run_busy", {31'd0, busy}, {31'd0, running});
      chk("run_done", {31'd0, done}, {31'd0, !running});
      chk("run_ready", {31'd0, cif.cmd_ready}, 32'd0);
    end
    if (running) chk("move_timeout", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("end_ready", {31'd0, cif.cmd_ready}, 32'd1);
    chk("end_done", {31'd0, done}, 32'd0);
    chk("end_busy", {31'd0, busy}, 32'd0);
    chk("end_left", {24'd0, steps_left}, n - issued);
    chk("end_phase", {28'd0, phase}, {28'd0, pat(pos)});
  endtask

  initial begin
    int n;
    int ab_at;
    rst           = 1'b0;
    abort         = 1'b0;
    cif.cmd_valid = 1'b0;
    cif.cmd_dir   = 1'b0;
    cif.cmd_steps = '0;
    cif.cmd_div   = '0;
    repeat (3) @(negedge clk);
    chk("rst_phase", {28'd0, phase}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, cif.cmd_ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_left", {24'd0, steps_left}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Forward 3 steps, period 2
    do_move(DIR_FWD, 3, 1, -1, 1'b0, 1'b0, 0, 0);
    chk("fwd_phase", {28'd0, phase}, 32'h7);

    // Full wrap then one reverse step (re-home to 0 first)
    do_move(DIR_REV, 3, 0, -1, 1'b0, 1'b0, 0, 0);
    do_move(DIR_FWD, 8, 0, -1, 1'b0, 1'b0, 0, 0);
    chk("wrap_phase", {28'd0, phase}, 32'h0);
    do_move(DIR_REV, 1, 0, -1, 1'b0, 1'b0, 0, 0);
    chk("rev_phase", {28'd0, phase}, 32'h8);

    // Abort after 4 steps
    do_move(DIR_FWD, 10, 0, 4, 1'b0, 1'b0, 0, 0);
    chk("abort_left", {24'd0, steps_left}, 32'd6);

    // Zero-length move
    do_move(DIR_FWD, 0, 3, -1, 1'b0, 1'b0, 0, 0);

    // Second command held during a move, then executed
    do_move(DIR_FWD, 5, 2, -1, 1'b1, DIR_REV, 3, 1);
    do_move(DIR_REV, 3, 1, -1, 1'b0, 1'b0, 0, 0);

    // Abort while idle is ignored
    abort = 1'b1;
    repeat (2) @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_busy", {31'd0, busy}, 32'd0);
    chk("idle_abort_done", {31'd0, done}, 32'd0);
    chk("idle_abort_phase", {28'd0, phase}, {28'd0, pat(pos)});

    for (int i = 0; i < 25; i++) begin
      n = int'($urandom_range(0, 12));
      ab_at = -1;
      if (n > 0 && $urandom_range(0, 3) == 0) ab_at = int'($urandom_range(0, n - 1));
      do_move(1'($urandom_range(0, 1)), n, int'($urandom_range(0, 3)), ab_at,
              1'b0, 1'b0, 0, 0);
    end

    // Reset mid-move: re-home, start a move, reset asynchronously after 3 steps
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    pos = 0;
    cif.cmd_dir   = DIR_FWD;
    cif.cmd_steps = 8'd10;
    cif.cmd_div   = 8'd0;
    cif.cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst_phase", {28'd0, phase}, 32'h7);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    chk("async_rst_phase", {28'd0, phase}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_ready", {31'd0, cif.cmd_ready}, 32'd1);
    chk("async_rst_left", {24'd0, steps_left}, 32'd0);
    chk("async_rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
